// File: rtl/ahb_gpio_bank_if.sv
// AHB-Lite bus bundle between a master and the ahb_gpio_bank slave.
// Accepted when hsel & htrans[1] & hready are high on a clock edge; the data phase ends on the next edge with hready high.
interface ahb_gpio_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hwrite;
  logic                  hsel;
  logic [1:0]            htrans;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    output haddr, hwdata, hwrite, hsel, htrans, hsize,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwdata, hwrite, hsel, htrans, hsize,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_gpio_bank.sv
// AHB-Lite GPIO bank: per-port OUT/DIR registers, synchronised IN, and a two-cycle ERROR response.
// Define GPIO_IRQ_EN to build the rising-edge interrupt unit (IRQ_EN, IRQ_STAT, irq).
module ahb_gpio_bank #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
  parameter int                    NUM_PORTS   = 2,
  parameter int                    PORT_WIDTH  = 16,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  ahb_gpio_bank_if.slave                  bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe,
  output logic                            irq,
  output logic [1:0]                      dbg_state_o
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int BL   = $clog2(NB);
  localparam int PI_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int NPIN = NUM_PORTS * PORT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] NWORDS = ADDR_WIDTH'(NUM_PORTS * 8);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ERR1 = 2'd1, S_ERR2 = 2'd2} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] offset, word_idx;
  logic [2:0]            reg_sel;
  logic [PI_W-1:0]       port_sel;
  logic                  accept, illegal;
  logic [NB-1:0]         lane_mask;
  int                    sz, lane;

  logic                  wr_pend_q;
  logic [PI_W-1:0]       wr_port_q;
  logic [2:0]            wr_reg_q;
  logic [NB-1:0]         wr_bmask_q;
  logic [DATA_WIDTH-1:0] wr_bm;
  logic [PORT_WIDTH-1:0] wdat, wmsk;

  logic [PORT_WIDTH-1:0] out_q [NUM_PORTS];
  logic [PORT_WIDTH-1:0] out_d [NUM_PORTS];
  logic [PORT_WIDTH-1:0] dir_q [NUM_PORTS];
  logic [PORT_WIDTH-1:0] dir_d [NUM_PORTS];
  logic [NPIN-1:0]       sync_q [SYNC_STAGES];
  logic [NPIN-1:0]       pin_s;
  logic [DATA_WIDTH-1:0] rd_word, hrdata_q;
  logic                  hready_o, hresp_o;

  // Address decode and byte-lane mask; sizes wider than the bus collapse to a full word.
  always_comb begin
    offset   = bus.haddr - START_ADDR;
    word_idx = offset >> BL;
    reg_sel  = word_idx[2:0];
    port_sel = word_idx[3 +: PI_W];
    accept   = bus.hsel & bus.htrans[1] & hready_o;
    illegal  = (word_idx >= NWORDS) | (reg_sel > 3'd4) | (bus.hwrite & (reg_sel == 3'd0));
    sz       = (int'(bus.hsize) > BL) ? BL : int'(bus.hsize);
    lane     = int'(offset[BL-1:0]);
    for (int b = 0; b < NB; b++) lane_mask[b] = ((b >> sz) == (lane >> sz));
  end

  always_comb begin
    wr_bm = '0;
    for (int b = 0; b < NB; b++) wr_bm[b*8 +: 8] = {8{wr_bmask_q[b]}};
    wdat = bus.hwdata[PORT_WIDTH-1:0];
    wmsk = wr_bm[PORT_WIDTH-1:0];
  end

  assign pin_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr_pend_q && wr_reg_q == 3'd1)
      out_d[wr_port_q] = (out_q[wr_port_q] & ~wmsk) | (wdat & wmsk);
    if (wr_pend_q && wr_reg_q == 3'd2)
      dir_d[wr_port_q] = (dir_q[wr_port_q] & ~wmsk) | (wdat & wmsk);
  end

`ifdef GPIO_IRQ_EN
  logic [PORT_WIDTH-1:0] en_q   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] en_d   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] stat_q [NUM_PORTS];
  logic [PORT_WIDTH-1:0] stat_d [NUM_PORTS];
  logic [NPIN-1:0]       prev_q, rise;
  logic                  irq_q;

  // A new edge wins over a same-cycle W1C, so the set is applied last.
  always_comb begin
    rise   = pin_s & ~prev_q;
    en_d   = en_q;
    stat_d = stat_q;
    if (wr_pend_q && wr_reg_q == 3'd3)
      en_d[wr_port_q] = (en_q[wr_port_q] & ~wmsk) | (wdat & wmsk);
    if (wr_pend_q && wr_reg_q == 3'd4)
      stat_d[wr_port_q] = stat_q[wr_port_q] & ~(wdat & wmsk);
    for (int p = 0; p < NUM_PORTS; p++)
      stat_d[p] = stat_d[p] | (en_q[p] & rise[p*PORT_WIDTH +: PORT_WIDTH]);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      prev_q <= '0;
      irq_q  <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        en_q[p]   <= '0;
        stat_q[p] <= '0;
      end
    end else begin
      prev_q <= pin_s;
      en_q   <= en_d;
      stat_q <= stat_d;
      irq_q  <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++)
        if (|stat_q[p]) irq_q <= 1'b1;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Reads see the next-state values, which forwards a same-cycle committing write.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      3'd0: rd_word[PORT_WIDTH-1:0] = pin_s[int'(port_sel)*PORT_WIDTH +: PORT_WIDTH];
      3'd1: rd_word[PORT_WIDTH-1:0] = out_d[port_sel];
      3'd2: rd_word[PORT_WIDTH-1:0] = dir_d[port_sel];
`ifdef GPIO_IRQ_EN
      3'd3: rd_word[PORT_WIDTH-1:0] = en_d[port_sel];
      3'd4: rd_word[PORT_WIDTH-1:0] = stat_d[port_sel];
`endif
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_pend_q  <= 1'b0;
      wr_port_q  <= '0;
      wr_reg_q   <= '0;
      wr_bmask_q <= '0;
      hrdata_q   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_q[p] <= '0;
        dir_q[p] <= '0;
      end
    end else begin
      wr_pend_q <= accept & ~illegal & bus.hwrite;
      if (accept) begin
        wr_port_q  <= port_sel;
        wr_reg_q   <= reg_sel;
        wr_bmask_q <= lane_mask;
      end
      if (accept & ~illegal & ~bus.hwrite) hrdata_q <= rd_word;
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept & illegal) state_d = S_ERR1;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = (accept & illegal) ? S_ERR1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hready_o    = (state_q != S_ERR1);
    hresp_o     = (state_q != S_IDLE);
    dbg_state_o = state_q;
  end

  always_comb begin
    gpio_out = '0;
    gpio_oe  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gpio_out[p*PORT_WIDTH +: PORT_WIDTH] = out_q[p];
      gpio_oe[p*PORT_WIDTH +: PORT_WIDTH]  = dir_q[p];
    end
  end

  assign bus.hready = hready_o;
  assign bus.hresp  = hresp_o;
  assign bus.hrdata = hrdata_q;
endmodule

// File: tb/tb_ahb_gpio_bank.sv
// Directed bench for ahb_gpio_bank: register access, byte lanes, forwarding, errors, input sync and interrupts.
module tb_ahb_gpio_bank;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NP = 2;
  localparam int PW = 16;
  localparam int SS = 2;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic [NP*PW-1:0]  gpio_in = '0;
  logic [NP*PW-1:0]  gpio_out, gpio_oe;
  logic              irq;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [PW-1:0] r0, r1;

  ahb_gpio_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ahb_gpio_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR('0),
    .NUM_PORTS(NP), .PORT_WIDTH(PW), .SYNC_STAGES(SS)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .irq(irq), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [AW-1:0] a, input logic [2:0] sz);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.hwrite = wr;
    bus.haddr  = a;
    bus.hsize  = sz;
  endtask

  task automatic check_rdata(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=scoreboard_entry", tag, bus.hrdata);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.hrdata, e);
    end
  endtask

  // address phase, then data phase; returns just after the commit edge
  task automatic do_write(input logic [AW-1:0] a, input logic [2:0] sz, input logic [DW-1:0] d);
    addr_phase(1'b1, a, sz);
    tick();
    bus_idle();
    bus.hwdata = d;
    check("wr_resp", {bus.hready, bus.hresp}, 2'b10);
    tick();
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
    exp_q.push_back(e);
    addr_phase(1'b0, a, 3'd2);
    tick();
    bus_idle();
    check_rdata(tag);
  endtask

  // illegal transfer; an address phase offered during ERR1 must be ignored
  task automatic err_seq(input string tag, input logic wr, input logic [AW-1:0] a, input logic [NP*PW-1:0] exp_out);
    addr_phase(wr, a, 3'd2);
    tick();
    check({tag, "_err1"}, {bus.hready, bus.hresp}, 2'b01);
    addr_phase(1'b1, 32'h24, 3'd2);
    bus.hwdata = 32'h0000_0F0F;
    tick();
    check({tag, "_err2"}, {bus.hready, bus.hresp}, 2'b11);
    bus_idle();
    bus.hwdata = 32'h0000_3333;
    tick();
    check({tag, "_okay"}, {bus.hready, bus.hresp}, 2'b10);
    check({tag, "_gpio"}, gpio_out, exp_out);
  endtask

  initial begin
    bus_idle();
    bus.haddr  = '0;
    bus.hwdata = '0;
    bus.hsize  = 3'd2;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hrdata", bus.hrdata, 32'h0);
    check("rst_resp", {bus.hready, bus.hresp}, 2'b10);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    check("rst_irq", irq, 1'b0);
    HRESET = 1'b0;
    tick();

    // port 1 OUT / DIR and readback
    do_write(32'h24, 3'd2, 32'h0000_A5A5);
    check("p1_out", gpio_out, 32'hA5A5_0000);
    do_write(32'h28, 3'd2, 32'h0000_FFFF);
    check("p1_oe", gpio_oe, 32'hFFFF_0000);
    do_read("rd_p1_out", 32'h24, 32'h0000_A5A5);
    do_read("rd_p1_dir", 32'h28, 32'h0000_FFFF);

    // upper bits dropped, byte and halfword lanes, oversize hsize
    do_write(32'h04, 3'd2, 32'hDEAD_1234);
    do_read("rd_p0_out_trunc", 32'h04, 32'h0000_1234);
    do_write(32'h05, 3'd0, 32'h0000_3C00);
    check("byte_gpio", gpio_out, 32'hA5A5_3C34);
    do_read("rd_byte", 32'h04, 32'h0000_3C34);
    do_write(32'h06, 3'd1, 32'hBEEF_0000);
    do_read("rd_hi_half", 32'h04, 32'h0000_3C34);
    do_write(32'h08, 3'd3, 32'h1234_00F0);
    check("oversize_oe", gpio_oe, 32'hFFFF_00F0);

    // write immediately followed by a read of the same word
    addr_phase(1'b1, 32'h04, 3'd2);
    tick();
    bus.hwdata = 32'h0000_0055;
    exp_q.push_back(32'h0000_0055);
    addr_phase(1'b0, 32'h04, 3'd2);
    tick();
    bus_idle();
    check_rdata("fwd_read");
    check("fwd_gpio", gpio_out, 32'hA5A5_0055);

    // illegal transfers
    err_seq("wr_in", 1'b1, 32'h20, 32'hA5A5_0055);
    err_seq("rd_w5", 1'b0, 32'h34, 32'hA5A5_0055);
    err_seq("rd_oor", 1'b0, 32'h40, 32'hA5A5_0055);
    do_read("p1_out_kept", 32'h24, 32'h0000_A5A5);

    // input synchroniser latency
    r0 = 16'($urandom_range(1, 65535));
    r1 = 16'($urandom_range(1, 65535));
    gpio_in = {r1, r0};
    tick();
    do_read("in_early", 32'h00, 32'h0);
    do_read("in_p0", 32'h00, {16'h0, r0});
    do_read("in_p1", 32'h20, {16'h0, r1});
    gpio_in = '0;
    repeat (4) tick();

`ifdef GPIO_IRQ_EN
    do_write(32'h0C, 3'd2, 32'h0000_0001);
    do_read("rd_en", 32'h0C, 32'h0000_0001);
    gpio_in[0] = 1'b1;
    repeat (SS + 1) tick();
    check("irq_not_yet", irq, 1'b0);
    tick();
    check("irq_high", irq, 1'b1);
    do_read("rd_stat", 32'h10, 32'h0000_0001);
    do_write(32'h10, 3'd2, 32'h0000_0001);
    check("irq_before_fall", irq, 1'b1);
    tick();
    check("irq_cleared", irq, 1'b0);
    do_read("rd_stat_clr", 32'h10, 32'h0);
    gpio_in[0] = 1'b0;
    repeat (4) tick();
    gpio_in[0] = 1'b1;
    repeat (5) tick();
    gpio_in[0] = 1'b0;
    repeat (4) tick();
    gpio_in[0] = 1'b1;
    tick();
    do_write(32'h10, 3'd2, 32'h0000_0001);
    do_read("stat_set_wins", 32'h10, 32'h0000_0001);
    check("irq_kept", irq, 1'b1);
`else
    do_write(32'h0C, 3'd2, 32'h0000_FFFF);
    do_read("rd_en_absent", 32'h0C, 32'h0);
    gpio_in[0] = 1'b1;
    repeat (5) tick();
    do_read("rd_stat_absent", 32'h10, 32'h0);
    check("irq_absent", irq, 1'b0);
`endif

    // reset in the middle of an error response
    addr_phase(1'b1, 32'h20, 3'd2);
    tick();
    bus_idle();
    check("pre_rst_err1", {bus.hready, bus.hresp}, 2'b01);
    HRESET = 1'b1;
    #1;
    check("rst_err_resp", {bus.hready, bus.hresp}, 2'b10);
    check("rst_err_gpio", gpio_out, 32'h0);
    check("rst_err_oe", gpio_oe, 32'h0);
    check("rst_err_irq", irq, 1'b0);
    tick();
    HRESET = 1'b0;
    tick();
    do_read("post_rst_out", 32'h24, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_gpio_bank.md
# ahb_gpio_bank

Parametrised AHB-Lite GPIO slave: NUM_PORTS ports of PORT_WIDTH pins, each with per-pin output-enable, synchronised inputs, and an optional rising-edge interrupt unit. Zero-wait-state for legal transfers, proper two-cycle ERROR response for illegal ones, byte-lane writes, and write-to-read forwarding. Sits on the system AHB beside memory and drives board pins through a top-level tristate wrapper.

## Interface
- DATA_WIDTH, 32, bus data width (32 or 64)
- ADDR_WIDTH, 32, bus address width
- START_ADDR, 0, base address of the block
- NUM_PORTS, 2, number of GPIO ports (1..16)
- PORT_WIDTH, 16, pins per port (1..DATA_WIDTH)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- HCLK  in  1  bus clock, sole clock
- HRESET  in  1  asynchronous active-high reset
- haddr  in  ADDR_WIDTH  address-phase address
- hwdata  in  DATA_WIDTH  data-phase write data
- hwrite, hsel  in  1  transfer direction / slave select
- htrans  in  2  transfer type; bit 1 high = NONSEQ/SEQ
- hsize  in  3  transfer size
- hrdata  out  DATA_WIDTH  read data, registered
- hready  out  1  transfer done
- hresp  out  1  0 OKAY, 1 ERROR
- gpio_in  in  NUM_PORTS*PORT_WIDTH  asynchronous pin inputs
- gpio_out  out  NUM_PORTS*PORT_WIDTH  output values
- gpio_oe  out  NUM_PORTS*PORT_WIDTH  output enables, 1 = drive
- irq  out  1  OR of all pending interrupt bits

## Operation
- Offset = haddr - START_ADDR. Port p occupies 8 words at p*8*(DATA_WIDTH/8). Word r: 0 IN (RO, synchronised pins), 1 OUT, 2 DIR (oe), 3 IRQ_EN, 4 IRQ_STAT (W1C). Words 5..7 reserved.
- Bits above PORT_WIDTH read 0, ignore writes.
- Address phase accepted when hsel & htrans[1] & hready. Offset beyond NUM_PORTS*8 words, reserved word, or write to IN -> ERROR; no register changes.
- Byte lanes: mask from hsize and offset low bits; hsize larger than DATA_WIDTH treated as full word. Only masked bytes updated; IRQ_STAT clear uses masked hwdata bits.
- Read returns full word (no lane masking).
- Forwarding: read accepted in the cycle a write to the same word commits returns post-write value.
- Inputs: each pin passes SYNC_STAGES flops; IN shows final stage.
- Edge unit: synchronised rising edge on pin with IRQ_EN=1 sets IRQ_STAT bit. Set and W1C on same bit same cycle -> bit stays set. irq = |IRQ_STAT, registered.
- Response FSM: IDLE -> (illegal accepted) ERR1: hready=0, hresp=1 -> ERR2: hready=1, hresp=1 -> IDLE. Address phase presented during ERR1 is ignored; master repeats/cancels per AHB.
- Reset (async, any cycle incl. mid-transfer or mid-error): hrdata=0, hready=1, hresp=0, gpio_out=0, gpio_oe=0, IRQ_EN=0, IRQ_STAT=0, irq=0, synchronisers=0, FSM IDLE; pending write discarded.

## Timing
- Address phase in cycle N; write data sampled in N+1, committed at end of N+1; gpio_out/gpio_oe change after that edge.
- Read: hrdata registered at end of N, valid throughout N+1 (one-cycle latency, zero wait states).
- Back-to-back transfers every cycle supported with no stalls unless ERROR.
- Pin edge to IN visible: SYNC_STAGES cycles; to IRQ_STAT set: SYNC_STAGES+1; to irq high: SYNC_STAGES+2.
- W1C committed end of N+1; irq falls one cycle later if no other bits pending.

## Configuration
- GPIO_IRQ_EN defined: edge detector, IRQ_EN, IRQ_STAT and irq present as above.
- Not defined: words 3 and 4 read 0, writes accepted with OKAY and ignored, irq tied 0; no edge-detect flops synthesised.

## Test plan
- Reset, write 0x0000_A5A5 to port 1 OUT, then DIR 0xFFFF -> gpio_out[31:16]=0xA5A5 and gpio_oe[31:16]=0xFFFF one cycle after each data phase; readback 0xA5A5.
- Byte write hsize=0 to OUT offset+1 with hwdata 0x0000_3C00 over 0x1234 -> OUT=0x3C34.
- Write OUT=0x55 then immediate read of OUT in next address phase -> hrdata=0x55.
- Write to IN and read of word 5 -> hready low 1 cycle with hresp=1, then hready=1 hresp=1; registers unchanged.
- GPIO_IRQ_EN: IRQ_EN=0x1, raise gpio_in[0] -> irq high SYNC_STAGES+2 cycles later, IRQ_STAT=0x1; W1C 0x1 -> irq low; edge coincident with W1C keeps bit set.
- Assert HRESET during ERR1 -> hready=1, hresp=0, gpio_out=0 immediately.
